// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: register-file geometry, scoreboard FSM
// encodings and base opcode constants.
package riscv_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/sb_pend_counter.sv
// Saturating up/down counter of outstanding writes to one architectural register.
module sb_pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic at_max
);

  logic [CNT_W-1:0] count;

  assign zero   = (count == '0);
  assign at_max = (count == '1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue scoreboard: per-register pending-write counters, RAW/WAW
// hazard stall, writeback retirement, drain and flush sequencing.
module issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [ADDR_W-1:0]  issue_rs1,
  input  logic [ADDR_W-1:0]  issue_rs2,
  input  logic               issue_use_rs1,
  input  logic               issue_use_rs2,
  input  logic [ADDR_W-1:0]  issue_rd,
  input  logic               issue_wr_rd,
  input  logic               wb_enable,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic               flush,
  input  logic               drain_req,
  output logic               drain_done,
  output logic               busy,
  output logic               wb_error,
  output logic [STALL_W-1:0] stall_count
);

  sb_state_e state, state_next;

  logic [NUM_REGS-1:0] cnt_zero;
  logic [NUM_REGS-1:0] cnt_max;
  logic raw1, raw2, sat, issue_fire, wb_live, wb_bad;

  // x0 is hardwired zero, so it never holds a pending write.
  assign cnt_zero[0] = 1'b1;
  assign cnt_max[0]  = 1'b0;

  assign issue_fire = issue_valid & issue_ready;
  assign wb_live    = wb_enable & (state != SB_FLUSH) & !flush;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    localparam logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(r);

    sb_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .clr    (flush),
      .inc    (issue_fire & issue_wr_rd & (issue_rd == REG_ADDR)),
      .dec    (wb_live & (wb_addr == REG_ADDR)),
      .zero   (cnt_zero[r]),
      .at_max (cnt_max[r])
    );
  end

  // Hazards look only at registered counters: a writeback unblocks next cycle.
  assign raw1 = issue_use_rs1 & (issue_rs1 != X0) & !cnt_zero[issue_rs1];
  assign raw2 = issue_use_rs2 & (issue_rs2 != X0) & !cnt_zero[issue_rs2];
  assign sat  = issue_wr_rd   & (issue_rd  != X0) &  cnt_max[issue_rd];

  assign issue_ready = !reset & (state == SB_RUN) & !flush & !raw1 & !raw2 & !sat;
  assign busy        = ~&cnt_zero;
  assign wb_bad      = wb_live & ((wb_addr == X0) | cnt_zero[wb_addr]);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    drain_done = 1'b0;
    unique case (state)
      SB_RUN:   if (drain_req) state_next = SB_DRAIN;
      SB_DRAIN: begin
        drain_done = !busy;
        if (!drain_req) state_next = SB_RUN;
      end
      SB_FLUSH: state_next = drain_req ? SB_DRAIN : SB_RUN;
      default:  state_next = SB_RUN;
    endcase
    if (flush) state_next = SB_FLUSH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SB_RUN;
      wb_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_next;
      wb_error <= wb_bad;
      if (issue_valid && !issue_ready && (state != SB_FLUSH) && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: RAW, x0, WAW saturation, simultaneous
// issue/writeback, drain, flush and asynchronous reset.
module tb_issue_scoreboard;
  import riscv_pkg::*;

  logic              clock;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic              issue_use_rs1;
  logic              issue_use_rs2;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_wr_rd;
  logic              wb_enable;
  logic [ADDR_W-1:0] wb_addr;
  logic              flush;
  logic              drain_req;
  logic              drain_done;
  logic              busy;
  logic              wb_error;
  logic [15:0]       stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rd      (issue_rd),
    .issue_wr_rd   (issue_wr_rd),
    .wb_enable     (wb_enable),
    .wb_addr       (wb_addr),
    .flush         (flush),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .busy          (busy),
    .wb_error      (wb_error),
    .stall_count   (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs after the falling edge; checks follow 1 time unit later.
  task automatic drv(input logic v,
                     input logic [ADDR_W-1:0] rs1, input logic u1,
                     input logic [ADDR_W-1:0] rs2, input logic u2,
                     input logic [ADDR_W-1:0] rd,  input logic w,
                     input logic wbe, input logic [ADDR_W-1:0] wba,
                     input logic fl,  input logic dr);
    @(negedge clock);
    issue_valid   = v;
    issue_rs1     = rs1;
    issue_use_rs1 = u1;
    issue_rs2     = rs2;
    issue_use_rs2 = u2;
    issue_rd      = rd;
    issue_wr_rd   = w;
    wb_enable     = wbe;
    wb_addr       = wba;
    flush         = fl;
    drain_req     = dr;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b1; issue_rs1 = '0; issue_use_rs1 = 1'b0; issue_rs2 = '0;
    issue_use_rs2 = 1'b0; issue_rd = 5'd1; issue_wr_rd = 1'b1;
    wb_enable = 1'b0; wb_addr = '0; flush = 1'b0; drain_req = 1'b0;
    #2;
    check("rst_ready", issue_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_wb_error", wb_error, 0);
    check("rst_stall", stall_count, 0);
    @(negedge clock);
    reset = 1'b0;
    issue_valid = 1'b0;

    // RAW stall on x5
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); check("t1_issue_rd5", issue_ready, 1);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t1_raw_stall_a", issue_ready, 0);
    check("t1_busy", busy, 1);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t1_raw_stall_b", issue_ready, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0); check("t1_no_bypass", issue_ready, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t1_unblocked", issue_ready, 1);
    check("t1_busy_clear", busy, 0);
    check("t1_stall_count", stall_count, 3);
    check("t1_no_wb_error", wb_error, 0);

    // x0 is never tracked; bad writebacks pulse wb_error
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); check("t2_issue_rd0", issue_ready, 1);
    drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t2_read_x0", issue_ready, 1);
    check("t2_busy", busy, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); check("t2_err_not_yet", wb_error, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("t2_err_x0", wb_error, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0); check("t2_err_pulse_end", wb_error, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("t2_err_cnt0", wb_error, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("t2_err_clear", wb_error, 0);

    // WAW saturation on x7
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); check("t3_waw_1", issue_ready, 1);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); check("t3_waw_2", issue_ready, 1);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); check("t3_waw_3", issue_ready, 1);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); check("t3_sat_stall", issue_ready, 0);
    drv(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0); check("t3_sat_wb_cycle", issue_ready, 0);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); check("t3_waw_4", issue_ready, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("t3_busy_clear", busy, 0);
    check("t3_stall_count", stall_count, 5);
    check("t3_no_wb_error", wb_error, 0);

    // Simultaneous issue and writeback to x9
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); check("t4_issue_rd9", issue_ready, 1);
    drv(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0); check("t4_issue_wb_same", issue_ready, 1);
    drv(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0); check("t4_reader_stalls", issue_ready, 0);
    check("t4_busy", busy, 1);
    drv(1, 0, 0, 9, 1, 0, 0, 1, 9, 0, 0); check("t4_reader_wb", issue_ready, 0);
    drv(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0); check("t4_reader_go", issue_ready, 1);
    check("t4_busy_clear", busy, 0);
    check("t4_stall_count", stall_count, 7);

    // Drain with two pending writes
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); check("t5_issue_rd3", issue_ready, 1);
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0); check("t5_issue_rd4", issue_ready, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); check("t5_req_done0", drain_done, 0);
    drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1); check("t5_drain_ready", issue_ready, 0);
    check("t5_drain_done_a", drain_done, 0);
    check("t5_drain_busy", busy, 1);
    drv(1, 0, 0, 0, 0, 10, 1, 1, 3, 0, 1); check("t5_drain_done_b", drain_done, 0);
    drv(1, 0, 0, 0, 0, 10, 1, 1, 4, 0, 1); check("t5_drain_done_c", drain_done, 0);
    drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1); check("t5_drain_done", drain_done, 1);
    check("t5_busy_clear", busy, 0);
    check("t5_ready_held", issue_ready, 0);
    drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0); check("t5_done_until_exit", drain_done, 1);
    check("t5_ready_exit_cycle", issue_ready, 0);
    drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0); check("t5_run_ready", issue_ready, 1);
    check("t5_run_done0", drain_done, 0);
    check("t5_stall_count", stall_count, 12);
    drv(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0); check("t5_issue_rd11", issue_ready, 1);
    drv(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0); check("t5_issue_rd12", issue_ready, 1);

    // Flush with three pending writes
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0); check("t6_flush_ready", issue_ready, 0);
    check("t6_flush_busy", busy, 1);
    drv(1, 10, 1, 0, 0, 0, 0, 1, 11, 0, 0); check("t6_flushed_busy", busy, 0);
    check("t6_flush_cycle_ready", issue_ready, 0);
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t6_reader_issues", issue_ready, 1);
    check("t6_flush_wb_ignored", wb_error, 0);
    check("t6_stall_count", stall_count, 13);

    // Asynchronous reset in the middle of a stall
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); check("t6_issue_rd5", issue_ready, 1);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t6_stall_a", issue_ready, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t6_stall_b", issue_ready, 0);
    check("t6_pre_rst_busy", busy, 1);
    check("t6_pre_rst_stall", stall_count, 14);
    #2 reset = 1'b1;
    #1;
    check("t6_arst_ready", issue_ready, 0);
    check("t6_arst_busy", busy, 0);
    check("t6_arst_stall", stall_count, 0);
    check("t6_arst_drain_done", drain_done, 0);
    check("t6_arst_wb_error", wb_error, 0);
    @(negedge clock);
    reset = 1'b0;
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("t6_post_rst_ready", issue_ready, 1);
    check("t6_post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
